// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
//   state_t        : arbiter FSM states
//   req_id_t       : requester index (0 or 1)
//   MEM_BYTES      : size of the attached byte-addressed memory
//   MAX_WORD_ADDR  : highest byte address at which a 4-byte word fits
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef logic req_id_t;

   localparam int MEM_BYTES     = 1024;
   localparam int MAX_WORD_ADDR = 1020;

   // A word access (any write, or a read with bsel=0) touches addr..addr+3,
   // so it is only legal when that range stays inside the memory.
   function automatic logic word_addr_bad(input logic we, input logic bsel,
                                          input logic [31:0] addr);
      return (we || !bsel) && (addr > 32'(MAX_WORD_ADDR));
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals of mem_arbiter.
//   requester n : req, we, bsel, addr, wdata in; gnt, done, err, rdata out
//   memory      : mem_write, mem_address, mem_writedata out;
//                 mem_readbyte, mem_readword in (registered by the memory)
// modport slave  : the arbiter's view
// modport master : the environment's view (requesters + memory)
interface mem_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              req0, req1;
   logic              we0, we1;
   logic              bsel0, bsel1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0, gnt1;
   logic              done0, done1;
   logic              err0, err1;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_writedata;
   logic [7:0]        mem_readbyte;
   logic [DATA_W-1:0] mem_readword;

   modport slave (
      input  req0, req1, we0, we1, bsel0, bsel1, addr0, addr1, wdata0, wdata1,
      output gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
      output mem_write, mem_address, mem_writedata,
      input  mem_readbyte, mem_readword
   );

   modport master (
      output req0, req1, we0, we1, bsel0, bsel1, addr0, addr1, wdata0, wdata1,
      input  gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
      input  mem_write, mem_address, mem_writedata,
      output mem_readbyte, mem_readword
   );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin selector.
//   req   : request vector, bit n = requester n
//   last  : requester granted most recently
//   grant : one-hot winner (all zero when nobody requests)
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  req_id_t    last,
   output logic [1:0] grant
);

   always_comb begin
      grant = req;
      // On a tie the requester that did not win last time goes first.
      if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one byte-addressed memory with registered
// read outputs. One access every two cycles: grant (N), memory access (N+1),
// response with done/err/rdata (N+2); a new grant may overlap the response.
//   clock, reset_n : single clock, asynchronous active-low reset
//   bus            : requester and memory signals (mem_arbiter_if.slave)
//
// state  | meaning
// IDLE   | no access in flight; grants allowed
// ACCESS | latched request driven onto the memory port
// RESP   | done/err/rdata to owner; next grant allowed
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic          clock,
   input  logic          reset_n,
   mem_arbiter_if.slave  bus
);

   state_t            state, state_nx;
   req_id_t           last_q, owner_q;
   logic              we_q, bsel_q, err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic [1:0]        rr_grant, gnt;
   logic              take;
   req_id_t           win_id;
   logic              win_we, win_bsel;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic              resp;
   logic [DATA_W-1:0] resp_data;

   rr_arbiter2 u_rr (
      .req   ({bus.req1, bus.req0}),
      .last  (last_q),
      .grant (rr_grant)
   );

   always_comb begin
      state_nx = state;
      gnt      = 2'b00;
      case (state)
         IDLE, RESP: begin
            // gnt is combinational, so it must also be silenced by reset.
            gnt      = rr_grant & {2{reset_n}};
            state_nx = (|gnt) ? ACCESS : IDLE;
         end
         ACCESS:  state_nx = RESP;
         default: state_nx = IDLE;
      endcase
   end

   assign take      = |gnt;
   assign win_id    = gnt[1];
   assign win_we    = win_id ? bus.we1    : bus.we0;
   assign win_bsel  = win_id ? bus.bsel1  : bus.bsel0;
   assign win_addr  = win_id ? bus.addr1  : bus.addr0;
   assign win_wdata = win_id ? bus.wdata1 : bus.wdata0;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         we_q    <= 1'b0;
         bsel_q  <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state <= state_nx;
         if (take) begin
            last_q  <= win_id;
            owner_q <= win_id;
            we_q    <= win_we;
            bsel_q  <= win_bsel;
            err_q   <= word_addr_bad(win_we, win_bsel, 32'(win_addr));
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
         end
      end
   end

   assign bus.gnt0          = gnt[0];
   assign bus.gnt1          = gnt[1];
   assign bus.mem_address   = addr_q;
   assign bus.mem_writedata = wdata_q;
   assign bus.mem_write     = (state == ACCESS) && we_q && !err_q;

   always_comb begin
      resp_data = '0;
      if (!err_q && !we_q)
         resp_data = bsel_q ? {{(DATA_W-8){1'b0}}, bus.mem_readbyte} : bus.mem_readword;
   end

   assign resp       = (state == RESP);
   assign bus.done0  = resp && (owner_q == 1'b0);
   assign bus.done1  = resp && (owner_q == 1'b1);
   assign bus.err0   = bus.done0 && err_q;
   assign bus.err1   = bus.done1 && err_q;
   assign bus.rdata0 = bus.done0 ? resp_data : '0;
   assign bus.rdata1 = bus.done1 ? resp_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requests push expected responses per
// requester when granted; a negedge monitor pops and compares on every done.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clock;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   writes_seen = 0;
   int   writes_expected = 0;
   bit   preloaded = 0;

   exp_t exp_q0[$];
   exp_t exp_q1[$];
   int   lat_q0[$];
   int   lat_q1[$];
   int   grant_log[$];

   logic [7:0] mem_arr [MEM_BYTES];

   mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

   mem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model: little-endian bytes, registered read outputs.
   function automatic logic [31:0] rd_word(input logic [9:0] a);
      return {mem_arr[a + 10'd3], mem_arr[a + 10'd2], mem_arr[a + 10'd1], mem_arr[a]};
   endfunction

   always @(posedge clock) begin
      if (!preloaded) begin
         for (int i = 0; i < MEM_BYTES; i++) mem_arr[i] <= 8'h00;
         mem_arr[10'h010] <= 8'hEF;
         mem_arr[10'h011] <= 8'hBE;
         mem_arr[10'h012] <= 8'hAD;
         mem_arr[10'h013] <= 8'hDE;
         mem_arr[10'h3FC] <= 8'h01;
         mem_arr[10'h3FD] <= 8'h02;
         mem_arr[10'h3FE] <= 8'h03;
         mem_arr[10'h3FF] <= 8'h77;
         preloaded <= 1'b1;
      end else if (bus.mem_write) begin
         for (int k = 0; k < 4; k++)
            mem_arr[bus.mem_address + 10'(k)] <= bus.mem_writedata[8*k +: 8];
         writes_seen <= writes_seen + 1;
      end
      bus.mem_readbyte <= mem_arr[bus.mem_address];
      bus.mem_readword <= rd_word(bus.mem_address);
   end

   task automatic on_done(input int id, input logic [31:0] rdata, input logic err);
      exp_t e;
      int   g;
      checks++;
      if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
         errors++;
         $display("FAIL done%0d_unexpected: got done with rdata %h, required no done", id, rdata);
      end else begin
         if (id == 0) e = exp_q0.pop_front();
         else         e = exp_q1.pop_front();
         g = -100;
         if (id == 0 && lat_q0.size() > 0) g = lat_q0.pop_front();
         if (id == 1 && lat_q1.size() > 0) g = lat_q1.pop_front();
         check($sformatf("rdata%0d", id), rdata, e.rdata);
         check($sformatf("err%0d", id), 32'(err), 32'(e.err));
         check($sformatf("latency%0d", id), 32'(cyc - g), 32'd2);
      end
   endtask

   always @(negedge clock) begin
      cyc++;
      if (!reset_n) begin
         lat_q0.delete();
         lat_q1.delete();
      end else begin
         if (bus.gnt0 && bus.gnt1) check("one_gnt", 32'd2, 32'd1);
         if (bus.gnt0) begin grant_log.push_back(0); lat_q0.push_back(cyc); end
         if (bus.gnt1) begin grant_log.push_back(1); lat_q1.push_back(cyc); end
         if (bus.done0 && bus.done1) check("one_done", 32'd2, 32'd1);
         if (bus.done0) on_done(0, bus.rdata0, bus.err0);
         if (bus.done1) on_done(1, bus.rdata1, bus.err1);
         if (bus.err0 && !bus.done0) check("err0_without_done0", 32'd1, 32'd0);
         if (bus.err1 && !bus.done1) check("err1_without_done1", 32'd1, 32'd0);
      end
   end

   // Raise a request, wait (bounded) for its grant, then drop it and scribble
   // over the request fields, which the arbiter must ignore from then on.
   task automatic issue(input int id, input logic we, input logic bsel,
                        input logic [9:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input bit track);
      exp_t e;
      bit   got;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      got     = 1'b0;
      if (id == 0) begin
         bus.we0 = we; bus.bsel0 = bsel; bus.addr0 = addr; bus.wdata0 = wdata; bus.req0 = 1'b1;
      end else begin
         bus.we1 = we; bus.bsel1 = bsel; bus.addr1 = addr; bus.wdata1 = wdata; bus.req1 = 1'b1;
      end
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clock);
         if ((id == 0 && bus.gnt0) || (id == 1 && bus.gnt1)) got = 1'b1;
      end
      checks++;
      if (got) begin
         if (track) begin
            if (id == 0) exp_q0.push_back(e);
            else         exp_q1.push_back(e);
            if (we && !exp_err) writes_expected++;
         end
      end else begin
         errors++;
         $display("FAIL grant_timeout%0d: got no gnt within 20 cycles, required gnt", id);
      end
      @(posedge clock);
      #1;
      if (id == 0) begin
         bus.req0 = 1'b0; bus.we0 = 1'b1; bus.bsel0 = 1'b0; bus.addr0 = 10'h3FF; bus.wdata0 = '1;
      end else begin
         bus.req1 = 1'b0; bus.we1 = 1'b1; bus.bsel1 = 1'b0; bus.addr1 = 10'h3FF; bus.wdata1 = '1;
      end
   endtask

   initial begin
      reset_n = 1'b0;
      bus.req0 = 1'b0; bus.we0 = 1'b0; bus.bsel0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.req1 = 1'b0; bus.we1 = 1'b0; bus.bsel1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
      bus.req0 = 1'b1;
      repeat (2) @(negedge clock);
      check("rst_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
      check("rst_done_err", {28'd0, bus.done1, bus.done0, bus.err1, bus.err0}, 32'd0);
      check("rst_mem_write", 32'(bus.mem_write), 32'd0);
      check("rst_mem_address", 32'(bus.mem_address), 32'd0);
      check("rst_mem_writedata", bus.mem_writedata, 32'd0);
      check("rst_rdata0", bus.rdata0, 32'd0);
      check("rst_rdata1", bus.rdata1, 32'd0);
      bus.req0 = 1'b0;
      @(posedge clock);
      #1 reset_n = 1'b1;
      @(posedge clock);
      #1;

      // Tie fairness right after reset: order must be 0,1,0,1.
      grant_log.delete();
      fork
         begin
            issue(0, 1'b0, 1'b1, 10'h010, 32'h0, 32'h0000_00EF, 1'b0, 1'b1);
            issue(0, 1'b0, 1'b0, 10'h010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
         end
         begin
            issue(1, 1'b0, 1'b1, 10'h013, 32'h0, 32'h0000_00DE, 1'b0, 1'b1);
            issue(1, 1'b0, 1'b1, 10'h011, 32'h0, 32'h0000_00BE, 1'b0, 1'b1);
         end
      join
      repeat (4) @(posedge clock);
      #1;
      check("tie_grant_count", 32'(grant_log.size()), 32'd4);
      if (grant_log.size() == 4) begin
         check("tie_order0", 32'(grant_log[0]), 32'd0);
         check("tie_order1", 32'(grant_log[1]), 32'd1);
         check("tie_order2", 32'(grant_log[2]), 32'd0);
         check("tie_order3", 32'(grant_log[3]), 32'd1);
      end

      // Single word read of preloaded data.
      issue(0, 1'b0, 1'b0, 10'h010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
      repeat (4) @(posedge clock);
      #1;

      // Write then back-to-back byte read and word read by requester 1.
      issue(1, 1'b1, 1'b0, 10'h020, 32'h1122_3344, 32'h0, 1'b0, 1'b1);
      issue(1, 1'b0, 1'b1, 10'h022, 32'h0, 32'h0000_0022, 1'b0, 1'b1);
      issue(1, 1'b0, 1'b0, 10'h020, 32'h0, 32'h1122_3344, 1'b0, 1'b1);
      repeat (4) @(posedge clock);
      #1;

      // Top-of-memory boundary.
      issue(0, 1'b1, 1'b0, 10'h3FD, 32'hAABB_CCDD, 32'h0, 1'b1, 1'b1);
      issue(0, 1'b0, 1'b0, 10'h3FE, 32'h0, 32'h0, 1'b1, 1'b1);
      issue(0, 1'b0, 1'b1, 10'h3FF, 32'h0, 32'h0000_0077, 1'b0, 1'b1);
      issue(1, 1'b0, 1'b0, 10'h3FC, 32'h0, 32'h7703_0201, 1'b0, 1'b1);
      repeat (4) @(posedge clock);
      #1;
      check("boundary_mem_unchanged", {mem_arr[10'h3FF], mem_arr[10'h3FE], mem_arr[10'h3FD], mem_arr[10'h3FC]},
            32'h7703_0201);

      // Reset while a write is in ACCESS.
      issue(1, 1'b1, 1'b0, 10'h040, 32'h5566_7788, 32'h0, 1'b0, 1'b0);
      check("midop_mem_write_before", 32'(bus.mem_write), 32'd1);
      reset_n = 1'b0;
      #1;
      check("midop_mem_write_after", 32'(bus.mem_write), 32'd0);
      check("midop_mem_address", 32'(bus.mem_address), 32'd0);
      check("midop_done", {30'd0, bus.done1, bus.done0}, 32'd0);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      check("midop_mem_unchanged", rd_word(10'h040), 32'h0);
      issue(0, 1'b0, 1'b1, 10'h3FF, 32'h0, 32'h0000_0077, 1'b0, 1'b1);
      repeat (5) @(posedge clock);
      #1;
      check("midop_mem_unchanged_late", rd_word(10'h040), 32'h0);

      check("pending_exp0", 32'(exp_q0.size()), 32'd0);
      check("pending_exp1", 32'(exp_q1.size()), 32'd0);
      check("write_strobes", 32'(writes_seen), 32'(writes_expected));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
